// File: rtl/bubble_sort_ctrl.sv
// In-place unsigned ascending bubble sort of words 0..COUNT-1 in an attached synchronous-read memory.
// Define BSORT_EARLY_EXIT_EN to finish as soon as a whole pass performs no swap.
module bubble_sort_ctrl #(
    parameter int W     = 5,
    parameter int COUNT = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_we,
    output logic [W-1:0]  mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [W-1:0]  mem_raddr,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   swap_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD0  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] CMP  = 3'd3;
    localparam logic [2:0] WR0  = 3'd4;
    localparam logic [2:0] WR1  = 3'd5;
    localparam logic [2:0] NEXT = 3'd6;
    localparam logic [2:0] DONE = 3'd7;

    localparam logic [W-1:0] ONE = 1;

    logic [2:0]   state;
    logic [W-1:0] i;
    logic [W-1:0] p;
    logic         swapped;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         pass_end;
    logic         last_pass;

    // Pass p compares pairs (0,1)..(COUNT-2-p, COUNT-1-p).
    assign pass_end  = (int'(i) + 1) >= (COUNT - 1 - int'(p));
    assign last_pass = (int'(p) + 1) == (COUNT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            i          <= '0;
            p          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
            a          <= '0;
            b          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (COUNT >= 2) begin
                            i          <= '0;
                            p          <= '0;
                            swapped    <= 1'b0;
                            swap_count <= '0;
                            state      <= RD0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RD0: state <= RD1;
                RD1: begin
                    a     <= mem_rdata;
                    state <= CMP;
                end
                CMP: begin
                    b     <= mem_rdata;
                    state <= (a > mem_rdata) ? WR0 : NEXT;
                end
                WR0: state <= WR1;
                WR1: begin
                    swapped <= 1'b1;
                    if (swap_count != 16'hFFFF) begin
                        swap_count <= swap_count + 16'd1;
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    if (!pass_end) begin
                        i     <= i + ONE;
                        state <= RD0;
                    end else begin
                        p <= p + ONE;
                        if (last_pass) begin
                            state <= DONE;
`ifdef BSORT_EARLY_EXIT_EN
                        end else if (!swapped) begin
                            state <= DONE;
`endif
                        end else begin
                            i       <= '0;
                            swapped <= 1'b0;
                            state   <= RD0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode from registered state, so start never reaches mem_we combinationally.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = '0;
        case (state)
            RD0: mem_raddr = i;
            RD1: mem_raddr = i + ONE;
            WR0: begin
                mem_we    = 1'b1;
                mem_waddr = i;
                mem_wdata = b;
            end
            WR1: begin
                mem_we    = 1'b1;
                mem_waddr = i + ONE;
                mem_wdata = a;
            end
            default: ;
        endcase
    end

endmodule
